// File: rtl/dram_init_sequencer.sv
// LPDDR4 bring-up sequencer: debounced start button, PHY reset pulse, per-channel DFI init
// handshake with timeout and bounded retries, plus busy/done/fail status LEDs.

module dram_init_ch (
    input  logic clk,
    input  logic rst,
    input  logic init_complete,
    input  logic clr,
    input  logic wait_en,
    output logic comp_s,
    output logic done_q
);
    logic comp_m;

    always_ff @(posedge clk) begin
        if (rst) begin
            comp_m <= 1'b0;
            comp_s <= 1'b0;
            done_q <= 1'b0;
        end else begin
            comp_m <= init_complete;
            comp_s <= comp_m;
            // once a channel reports complete, its init_start stays low for the attempt
            if (clr)
                done_q <= 1'b0;
            else if (wait_en && comp_s)
                done_q <= 1'b1;
        end
    end
endmodule

module dram_init_sequencer #(
    parameter int NUM_CH       = 1,
    parameter int DEBOUNCE_CYC = 1000000,
    parameter int PHY_RST_CYC  = 256,
    parameter int TIMEOUT_CYC  = 50000000,
    parameter int MAX_RETRY    = 3,
    parameter int AUTO_START   = 0,
    parameter int HB_DIV       = 24,
    localparam int RW   = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              btn_start_n,
    output logic              phy_rst,
    output logic [NUM_CH-1:0] init_start,
    input  logic [NUM_CH-1:0] init_complete,
    output logic              led_busy,
    output logic              led_done,
    output logic              led_fail,
    output logic [RW-1:0]     retry_cnt
);
    localparam int CMAX = (TIMEOUT_CYC > PHY_RST_CYC) ? TIMEOUT_CYC : PHY_RST_CYC;
    localparam int CW   = $clog2(CMAX + 1);
    localparam int DW   = $clog2(DEBOUNCE_CYC + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_PHYRST, S_START, S_WAIT, S_DONE, S_FAIL
    } state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [RW-1:0]     retry_q, retry_d;
    logic              auto_pend;
    logic [HB_DIV:0]   hb_cnt;

    logic              btn_s1, btn_s2, btn_deb, press_evt;
    logic [DW-1:0]     deb_cnt;

    logic [NUM_CH-1:0] comp_s, done_q;
    logic              all_done;

    // debounce: level follows the synchronised button only after DEBOUNCE_CYC differing samples
    always_ff @(posedge clk) begin
        if (rst) begin
            btn_s1    <= 1'b1;
            btn_s2    <= 1'b1;
            btn_deb   <= 1'b1;
            deb_cnt   <= '0;
            press_evt <= 1'b0;
        end else begin
            btn_s1    <= btn_start_n;
            btn_s2    <= btn_s1;
            press_evt <= 1'b0;
            if (btn_s2 == btn_deb) begin
                deb_cnt <= '0;
            end else if (deb_cnt == DW'(DEBOUNCE_CYC - 1)) begin
                btn_deb   <= btn_s2;
                deb_cnt   <= '0;
                press_evt <= btn_deb;
            end else begin
                deb_cnt <= deb_cnt + 1'b1;
            end
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        dram_init_ch u_ch (
            .clk           (clk),
            .rst           (rst),
            .init_complete (init_complete[i]),
            .clr           (state_q == S_START),
            .wait_en       (state_q == S_WAIT),
            .comp_s        (comp_s[i]),
            .done_q        (done_q[i])
        );
    end

    assign all_done = &(done_q | comp_s);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            retry_q   <= '0;
            auto_pend <= (AUTO_START != 0);
            hb_cnt    <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            retry_q   <= retry_d;
            auto_pend <= 1'b0;
            hb_cnt    <= hb_cnt + 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        retry_d = retry_q;
        case (state_q)
            S_IDLE: begin
                if (press_evt || auto_pend) begin
                    state_d = S_PHYRST;
                    cnt_d   = '0;
                end
            end
            S_PHYRST: begin
                if (cnt_q == CW'(PHY_RST_CYC - 1)) begin
                    state_d = S_START;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_START: begin
                state_d = S_WAIT;
                cnt_d   = '0;
            end
            S_WAIT: begin
                // completion is checked first so it wins over a coincident timeout
                if (all_done) begin
                    state_d = S_DONE;
                end else if (cnt_q == CW'(TIMEOUT_CYC - 1)) begin
                    if (retry_q == RW'(MAX_RETRY)) begin
                        state_d = S_FAIL;
                    end else begin
                        retry_d = retry_q + 1'b1;
                        state_d = S_PHYRST;
                        cnt_d   = '0;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DONE: begin
                if (!(&comp_s) || press_evt) begin
                    state_d = S_PHYRST;
                    cnt_d   = '0;
                    retry_d = '0;
                end
            end
            S_FAIL: begin
                if (press_evt) begin
                    state_d = S_PHYRST;
                    cnt_d   = '0;
                    retry_d = '0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        for (int i = 0; i < NUM_CH; i++)
            init_start[i] = (state_q == S_WAIT) && !done_q[i];
    end

    assign phy_rst   = (state_q == S_PHYRST);
    assign led_busy  = hb_cnt[HB_DIV] &&
                       (state_q == S_PHYRST || state_q == S_START || state_q == S_WAIT);
    assign led_done  = (state_q == S_DONE);
    assign led_fail  = (state_q == S_FAIL);
    assign retry_cnt = retry_q;
endmodule

// File: tb/tb_dram_init_sequencer.sv
// Directed bench for dram_init_sequencer: two channels with a simple PHY latency model,
// plus an auto-start instance exercised across a mid-sequence reset.

module tb_dram_init_sequencer;
    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst = 1'b1;
    logic       btn_start_n = 1'b1;
    logic       phy_rst;
    logic [1:0] init_start;
    logic [1:0] init_complete;
    logic       led_busy, led_done, led_fail;
    logic [1:0] retry_cnt;

    logic       rst_a = 1'b1;
    logic       btn_a = 1'b1;
    logic [1:0] ic_a  = 2'b00;
    logic       phy_a, busy_a, done_a, fail_a;
    logic [1:0] ist_a;
    logic [1:0] retry_a;

    int n_chk  = 0;
    int n_fail = 0;

    dram_init_sequencer #(
        .NUM_CH(2), .DEBOUNCE_CYC(4), .PHY_RST_CYC(8), .TIMEOUT_CYC(100),
        .MAX_RETRY(2), .AUTO_START(0), .HB_DIV(2)
    ) u_dut (
        .clk(clk), .rst(rst), .btn_start_n(btn_start_n), .phy_rst(phy_rst),
        .init_start(init_start), .init_complete(init_complete), .led_busy(led_busy),
        .led_done(led_done), .led_fail(led_fail), .retry_cnt(retry_cnt)
    );

    dram_init_sequencer #(
        .NUM_CH(2), .DEBOUNCE_CYC(4), .PHY_RST_CYC(8), .TIMEOUT_CYC(100),
        .MAX_RETRY(2), .AUTO_START(1), .HB_DIV(2)
    ) u_auto (
        .clk(clk), .rst(rst_a), .btn_start_n(btn_a), .phy_rst(phy_a),
        .init_start(ist_a), .init_complete(ic_a), .led_busy(busy_a),
        .led_done(done_a), .led_fail(fail_a), .retry_cnt(retry_a)
    );

    // button driver: btn_hold cycles of press, released otherwise
    int btn_hold = 0;
    always @(negedge clk) begin
        if (btn_hold > 0) begin
            btn_start_n = 1'b0;
            btn_hold--;
        end else begin
            btn_start_n = 1'b1;
        end
    end

    // PHY model: channel completes after lat cycles of init_start (lat 0 = never)
    int         lat[2];
    int         pcnt[2];
    logic [1:0] mcomp = 2'b00;
    logic [1:0] force_low = 2'b00;
    assign init_complete = mcomp & ~force_low;

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (phy_rst || rst) begin
                pcnt[i]  = 0;
                mcomp[i] = 1'b0;
            end else if (init_start[i] && !mcomp[i]) begin
                pcnt[i]++;
                if (lat[i] != 0 && pcnt[i] >= lat[i]) mcomp[i] = 1'b1;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(4);
        n_chk++; if (phy_rst !== 1'b0)     begin n_fail++; $display("FAIL rst_phy_rst got %0b exp 0", phy_rst); end
        n_chk++; if (init_start !== 2'b00) begin n_fail++; $display("FAIL rst_init_start got %b exp 00", init_start); end
        n_chk++; if (led_busy !== 1'b0)    begin n_fail++; $display("FAIL rst_led_busy got %0b exp 0", led_busy); end
        n_chk++; if (led_done !== 1'b0)    begin n_fail++; $display("FAIL rst_led_done got %0b exp 0", led_done); end
        n_chk++; if (led_fail !== 1'b0)    begin n_fail++; $display("FAIL rst_led_fail got %0b exp 0", led_fail); end
        n_chk++; if (retry_cnt !== 2'd0)   begin n_fail++; $display("FAIL rst_retry got %0d exp 0", retry_cnt); end
        rst = 1'b0;
        tick(6);
        n_chk++; if (phy_rst !== 1'b0)     begin n_fail++; $display("FAIL idle_no_autostart got %0b exp 0", phy_rst); end
    endtask

    task automatic test_bounce();
        int saw = 0;
        for (int i = 0; i < 8; i++) begin
            btn_hold = 2;
            for (int j = 0; j < 4; j++) begin
                @(negedge clk);
                if (phy_rst || led_busy || init_start != 2'b00) saw = 1;
            end
        end
        for (int j = 0; j < 12; j++) begin
            @(negedge clk);
            if (phy_rst || led_busy || init_start != 2'b00) saw = 1;
        end
        n_chk++; if (saw !== 0)            begin n_fail++; $display("FAIL bounce_started got %0d exp 0", saw); end
        n_chk++; if (led_done !== 1'b0)    begin n_fail++; $display("FAIL bounce_led_done got %0b exp 0", led_done); end
    endtask

    task automatic test_normal();
        int w = 0;
        int k = 1;
        int hb_hi = 0;
        int hb_lo = 0;
        lat[0] = 20; lat[1] = 40;
        btn_hold = 10;
        for (int j = 0; j < 30 && phy_rst !== 1'b1; j++) @(negedge clk);
        n_chk++; if (phy_rst !== 1'b1)     begin n_fail++; $display("FAIL norm_phy_rise got %0b exp 1", phy_rst); end
        while (phy_rst === 1'b1 && w < 50) begin
            if (led_busy) hb_hi = 1; else hb_lo = 1;
            w++;
            @(negedge clk);
        end
        n_chk++; if (w !== 8)              begin n_fail++; $display("FAIL norm_phy_width got %0d exp 8", w); end
        n_chk++; if (init_start !== 2'b00) begin n_fail++; $display("FAIL norm_start_cycle got %b exp 00", init_start); end
        @(negedge clk);
        n_chk++; if (init_start !== 2'b11) begin n_fail++; $display("FAIL norm_wait_entry got %b exp 11", init_start); end
        while (init_start[0] === 1'b1 && k < 60) begin
            if (led_busy) hb_hi = 1; else hb_lo = 1;
            @(negedge clk);
            k++;
        end
        n_chk++; if (k < 21 || k > 25)     begin n_fail++; $display("FAIL norm_ch0_drop got %0d exp 21..25", k); end
        n_chk++; if (init_start !== 2'b10) begin n_fail++; $display("FAIL norm_ch1_held got %b exp 10", init_start); end
        n_chk++; if (hb_hi != 1 || hb_lo != 1) begin n_fail++; $display("FAIL norm_heartbeat got hi=%0d lo=%0d exp 1 1", hb_hi, hb_lo); end
        for (int j = 0; j < 80 && led_done !== 1'b1; j++) @(negedge clk);
        n_chk++; if (led_done !== 1'b1)    begin n_fail++; $display("FAIL norm_done got %0b exp 1", led_done); end
        n_chk++; if (init_start !== 2'b00) begin n_fail++; $display("FAIL norm_done_ist got %b exp 00", init_start); end
        n_chk++; if (retry_cnt !== 2'd0)   begin n_fail++; $display("FAIL norm_retry got %0d exp 0", retry_cnt); end
        n_chk++; if (led_busy !== 1'b0)    begin n_fail++; $display("FAIL norm_busy_off got %0b exp 0", led_busy); end
    endtask

    task automatic test_done_loss();
        int w = 0;
        force_low[1] = 1'b1;
        for (int j = 0; j < 10 && led_done !== 1'b0; j++) @(negedge clk);
        n_chk++; if (led_done !== 1'b0)    begin n_fail++; $display("FAIL loss_done_drop got %0b exp 0", led_done); end
        n_chk++; if (phy_rst !== 1'b1)     begin n_fail++; $display("FAIL loss_phy_rst got %0b exp 1", phy_rst); end
        force_low[1] = 1'b0;
        while (phy_rst === 1'b1 && w < 50) begin
            w++;
            @(negedge clk);
        end
        n_chk++; if (w !== 8)              begin n_fail++; $display("FAIL loss_phy_width got %0d exp 8", w); end
        for (int j = 0; j < 120 && led_done !== 1'b1; j++) @(negedge clk);
        n_chk++; if (led_done !== 1'b1)    begin n_fail++; $display("FAIL loss_reinit got %0b exp 1", led_done); end
        n_chk++; if (retry_cnt !== 2'd0)   begin n_fail++; $display("FAIL loss_retry got %0d exp 0", retry_cnt); end
    endtask

    task automatic test_timeout_fail();
        int rises = 0;
        int ist1 = 0;
        int rr[4] = '{-1, -1, -1, -1};
        logic prev = 1'b0;
        lat[1] = 0;
        btn_hold = 10;
        for (int j = 0; j < 700 && led_fail !== 1'b1; j++) begin
            @(negedge clk);
            if (phy_rst && !prev) begin
                if (rises < 4) rr[rises] = int'(retry_cnt);
                rises++;
            end
            if (init_start[1]) ist1++;
            prev = phy_rst;
        end
        n_chk++; if (led_fail !== 1'b1)    begin n_fail++; $display("FAIL to_led_fail got %0b exp 1", led_fail); end
        n_chk++; if (rises !== 3)          begin n_fail++; $display("FAIL to_attempts got %0d exp 3", rises); end
        n_chk++; if (ist1 !== 300)         begin n_fail++; $display("FAIL to_wait_cycles got %0d exp 300", ist1); end
        n_chk++; if (rr[0] !== 0 || rr[1] !== 1 || rr[2] !== 2)
            begin n_fail++; $display("FAIL to_retry_seq got %0d %0d %0d exp 0 1 2", rr[0], rr[1], rr[2]); end
        n_chk++; if (retry_cnt !== 2'd2)   begin n_fail++; $display("FAIL to_retry_final got %0d exp 2", retry_cnt); end
        tick(20);
        n_chk++; if (init_start !== 2'b00 || phy_rst !== 1'b0 || led_busy !== 1'b0 || led_done !== 1'b0)
            begin n_fail++; $display("FAIL to_fail_idle got ist=%b phy=%0b busy=%0b done=%0b exp 00 0 0 0", init_start, phy_rst, led_busy, led_done); end
        n_chk++; if (led_fail !== 1'b1)    begin n_fail++; $display("FAIL to_fail_hold got %0b exp 1", led_fail); end
    endtask

    task automatic test_fail_recover();
        lat[1] = 40;
        btn_hold = 10;
        for (int j = 0; j < 30 && phy_rst !== 1'b1; j++) @(negedge clk);
        n_chk++; if (phy_rst !== 1'b1)     begin n_fail++; $display("FAIL rec_phy_rise got %0b exp 1", phy_rst); end
        n_chk++; if (retry_cnt !== 2'd0)   begin n_fail++; $display("FAIL rec_retry_clr got %0d exp 0", retry_cnt); end
        n_chk++; if (led_fail !== 1'b0)    begin n_fail++; $display("FAIL rec_fail_clr got %0b exp 0", led_fail); end
        for (int j = 0; j < 200 && led_done !== 1'b1; j++) @(negedge clk);
        n_chk++; if (led_done !== 1'b1)    begin n_fail++; $display("FAIL rec_done got %0b exp 1", led_done); end
    endtask

    task automatic test_auto_rst();
        int c0 = 0;
        int c1 = 0;
        rst_a = 1'b0;
        for (int j = 0; j < 5 && phy_a !== 1'b1; j++) @(negedge clk);
        n_chk++; if (phy_a !== 1'b1)       begin n_fail++; $display("FAIL auto_start got %0b exp 1", phy_a); end
        for (int j = 0; j < 20 && ist_a !== 2'b11; j++) @(negedge clk);
        n_chk++; if (ist_a !== 2'b11)      begin n_fail++; $display("FAIL auto_wait got %b exp 11", ist_a); end
        tick(10);
        rst_a = 1'b1;
        @(negedge clk);
        n_chk++; if (phy_a !== 1'b0 || ist_a !== 2'b00 || busy_a !== 1'b0 || done_a !== 1'b0 || fail_a !== 1'b0 || retry_a !== 2'd0)
            begin n_fail++; $display("FAIL auto_midrst got phy=%0b ist=%b busy=%0b done=%0b fail=%0b retry=%0d exp all 0",
                                     phy_a, ist_a, busy_a, done_a, fail_a, retry_a); end
        ic_a  = 2'b11;
        rst_a = 1'b0;
        for (int j = 0; j < 5 && phy_a !== 1'b1; j++) @(negedge clk);
        n_chk++; if (phy_a !== 1'b1)       begin n_fail++; $display("FAIL auto_restart got %0b exp 1", phy_a); end
        for (int j = 0; j < 40 && done_a !== 1'b1; j++) begin
            @(negedge clk);
            if (ist_a[0]) c0++;
            if (ist_a[1]) c1++;
        end
        n_chk++; if (done_a !== 1'b1)      begin n_fail++; $display("FAIL auto_done got %0b exp 1", done_a); end
        n_chk++; if (c0 > 1 || c1 > 1)     begin n_fail++; $display("FAIL auto_prehigh_ist got %0d %0d exp <=1", c0, c1); end
    endtask

    initial begin
        lat[0] = 20;
        lat[1] = 40;
        test_reset();
        test_bounce();
        test_normal();
        test_done_loss();
        test_timeout_fail();
        test_fail_recover();
        test_auto_rst();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
